// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch front end.
// Issues in-order imem requests for the current PC, tags each request with its
// address, collects responses into a DEPTH-entry FIFO and presents the head to
// decode. A flush empties the FIFO and discards every response still in flight.
// Optional build macro FETCH_BUF_BYPASS_EN: a response arriving while the FIFO
// is empty is shown on IF_* in the same cycle (written only if decode stalls).
module fetch_buffer #(
   parameter int DEPTH           = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC,
   input  logic        flush,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        fetch_stall,
   output logic        IF_valid,
   output logic [31:0] IF_instr,
   output logic [31:0] IF_PC,
   input  logic        ID_ready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
   localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUTSTANDING - 1);
   localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0]   RESET_PC  = 32'h8000_0000;

   // Instruction FIFO storage and control
   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem    [DEPTH];
   logic [PW-1:0] head_ptr;
   logic [PW-1:0] tail_ptr;
   logic [CW-1:0] fifo_count;

   // In-order tag queue: one address per request still awaiting its response
   logic [31:0]   tag_mem [MAX_OUTSTANDING];
   logic [TW-1:0] tag_rd_ptr;
   logic [TW-1:0] tag_wr_ptr;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] kill_cnt;

   logic fifo_empty;
   logic issue_fire;
   logic resp_accept;
   logic resp_keep;
   logic bypass_hit;
   logic pop_fire;
   logic fifo_push;
   logic fifo_pop;

   assign fifo_empty    = (fifo_count == '0);
   assign imem_req_addr = PC;

   // Room check counts in-flight requests so every response has a FIFO slot.
   assign imem_req_valid = !rst && !flush
                         && (32'(outstanding) < MAX_OUTSTANDING)
                         && ((32'(fifo_count) + 32'(outstanding)) < 32'(DEPTH));
   assign issue_fire     = imem_req_valid && imem_req_ready;

   // A flush cycle must not stall so the PC register can take the redirect.
   assign fetch_stall = rst || (!flush && !issue_fire);

   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp_accept = !rst && imem_resp_valid && (outstanding != '0);
   assign resp_keep   = resp_accept && (kill_cnt == '0) && !flush;

`ifdef FETCH_BUF_BYPASS_EN
   assign bypass_hit = resp_keep && fifo_empty;
`else
   assign bypass_hit = 1'b0;
`endif

   assign IF_valid  = !rst && (!fifo_empty || bypass_hit);
   assign pop_fire  = IF_valid && ID_ready && !flush;
   // With the FIFO empty, a pop can only be consuming the bypassed response.
   assign fifo_pop  = pop_fire && !fifo_empty;
   assign fifo_push = resp_keep && !(bypass_hit && ID_ready);

   // Present the head entry (or the bypassed response); NOP at reset/empty.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      IF_instr = NOP_INSTR;
      IF_PC    = RESET_PC;
      if (!rst) begin
         if (!fifo_empty) begin
            IF_instr = instr_mem[head_ptr];
            IF_PC    = pc_mem[head_ptr];
         end else if (bypass_hit) begin
            IF_instr = imem_resp_data;
            IF_PC    = tag_mem[tag_rd_ptr];
         end
      end
   end

   // FIFO pointers/count: flush empties, push and pop together hold the count.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst || flush) begin
         head_ptr   <= '0;
         tail_ptr   <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) tail_ptr <= (tail_ptr == PTR_LAST) ? '0 : tail_ptr + PW'(1);
         if (fifo_pop)  head_ptr <= (head_ptr == PTR_LAST) ? '0 : head_ptr + PW'(1);
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: ;
         endcase
      end
   end

   // Tag queue pointers, outstanding count and kill count for flushed requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_rd_ptr  <= '0;
         tag_wr_ptr  <= '0;
         outstanding <= '0;
         kill_cnt    <= '0;
      end else begin
         if (issue_fire)  tag_wr_ptr <= (tag_wr_ptr == TAG_LAST) ? '0 : tag_wr_ptr + TW'(1);
         if (resp_accept) tag_rd_ptr <= (tag_rd_ptr == TAG_LAST) ? '0 : tag_rd_ptr + TW'(1);
         case ({issue_fire, resp_accept})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: ;
         endcase
         // Everything still in flight after this edge belongs to the old path.
         if (flush) begin
            kill_cnt <= outstanding - OW'(resp_accept);
         end else if (resp_accept && (kill_cnt != '0)) begin
            kill_cnt <= kill_cnt - OW'(1);
         end
      end
   end

   // Entry and tag storage writes.
   always_ff @(posedge clk) begin
      // NOTE: storage arrays are not reset; only pointers/counts define valid entries.
      if (fifo_push) begin
         instr_mem[tail_ptr] <= imem_resp_data;
         pc_mem[tail_ptr]    <= tag_mem[tag_rd_ptr];
      end
      if (issue_fire) tag_mem[tag_wr_ptr] <= PC;
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed bench for fetch_buffer with a queue-based model
// checked every cycle plus hand-computed literal expectations.
module tb_fetch_buffer;

   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 2;
`ifdef FETCH_BUF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] PC;
   logic        flush;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        fetch_stall;
   logic        IF_valid;
   logic [31:0] IF_instr;
   logic [31:0] IF_PC;
   logic        ID_ready;

   fetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk             (clk),
      .rst             (rst),
      .PC              (PC),
      .flush           (flush),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .fetch_stall     (fetch_stall),
      .IF_valid        (IF_valid),
      .IF_instr        (IF_instr),
      .IF_PC           (IF_PC),
      .ID_ready        (ID_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      m_fifo[$];
   logic [31:0] m_tags[$];
   int          m_kill   = 0;
   bit          model_on = 1'b0;

   function automatic logic exp_req_valid();
      return !rst && !flush && (m_tags.size() < MAX_OUT)
             && (m_fifo.size() + m_tags.size() < DEPTH);
   endfunction

   function automatic logic exp_accept();
      return !rst && imem_resp_valid && (m_tags.size() != 0);
   endfunction

   function automatic logic exp_bypass();
      return BYP && exp_accept() && (m_kill == 0) && !flush && (m_fifo.size() == 0);
   endfunction

   function automatic logic exp_if_valid();
      return !rst && ((m_fifo.size() != 0) || exp_bypass());
   endfunction

   function automatic logic exp_stall();
      return rst || (!flush && !(exp_req_valid() && imem_req_ready));
   endfunction

   // Model state advances on each edge from the inputs present at that edge.
   always @(posedge clk) begin : model_update
      logic        acc;
      logic        iss;
      logic        byp;
      logic        pop;
      logic [31:0] t;
      if (rst) begin
         m_fifo.delete();
         m_tags.delete();
         m_kill = 0;
      end else begin
         acc = exp_accept();
         iss = exp_req_valid() && imem_req_ready;
         byp = exp_bypass();
         pop = exp_if_valid() && ID_ready && !flush;
         if (flush) begin
            if (acc) void'(m_tags.pop_front());
            m_kill = m_tags.size();
            m_fifo.delete();
         end else begin
            if (pop && (m_fifo.size() != 0)) void'(m_fifo.pop_front());
            if (acc) begin
               t = m_tags.pop_front();
               if (m_kill > 0) m_kill--;
               else if (!(byp && ID_ready)) m_fifo.push_back('{pc: t, instr: imem_resp_data});
            end
            if (iss) m_tags.push_back(PC);
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (model_on) begin
         check("req_valid", 32'(imem_req_valid), 32'(exp_req_valid()));
         check("fetch_stall", 32'(fetch_stall), 32'(exp_stall()));
         check("IF_valid", 32'(IF_valid), 32'(exp_if_valid()));
         check("req_addr", imem_req_addr, PC);
         if (exp_if_valid()) begin
            if (m_fifo.size() != 0) begin
               check("IF_instr", IF_instr, m_fifo[0].instr);
               check("IF_PC", IF_PC, m_fifo[0].pc);
            end else begin
               check("IF_instr_byp", IF_instr, imem_resp_data);
               check("IF_PC_byp", IF_PC, m_tags[0]);
            end
         end
      end
   end

   // ---------------- stimulus: PC register and memory responder ----------------
   logic [31:0] pend[$];
   logic [31:0] redirect_pc = 32'h0;
   bit          resp_hold   = 1'b0;
   int          n_issued    = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h8000_0000: return 32'h0050_0093;
         32'h8000_0004: return 32'h0010_8113;
         default:       return {a[15:0], 16'h0013};
      endcase
   endfunction

   // One clock: sample at negedge, then update PC and responder after posedge.
   task automatic tick();
      logic        stall_s, flush_s, rst_s, iss_s;
      logic [31:0] addr_s;
      @(negedge clk);
      stall_s = fetch_stall;
      flush_s = flush;
      rst_s   = rst;
      iss_s   = imem_req_valid && imem_req_ready;
      addr_s  = imem_req_addr;
      @(posedge clk);
      #1;
      if (rst_s)        PC = 32'h8000_0000;
      else if (flush_s) PC = redirect_pc;
      else if (!stall_s) PC = PC + 32'd4;
      if (iss_s && !rst_s) begin
         pend.push_back(addr_s);
         n_issued++;
      end
      if (!resp_hold && (pend.size() != 0)) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(pend.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'h0;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int snap;
      rst = 1'b1; flush = 1'b1; PC = 32'h0;
      imem_req_ready = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hFFFF_FFFF;
      ID_ready = 1'b1;

      // Reset overrides flush and a response on the bus.
      tick();
      model_on = 1'b1;
      imem_resp_valid = 1'b1;
      tick();
      imem_resp_valid = 1'b1;
      settle();
      check("rst_IF_valid", 32'(IF_valid), 32'h0);
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check("rst_stall", 32'(fetch_stall), 32'h1);
      check("rst_IF_instr", IF_instr, 32'h0000_0013);
      check("rst_IF_PC", IF_PC, 32'h8000_0000);

      // Stream: two requests, 1-cycle responses.
      rst = 1'b0; flush = 1'b0; imem_resp_valid = 1'b0;
      settle();
      check("A_req_valid", 32'(imem_req_valid), 32'h1);
      check("A_req_addr", imem_req_addr, 32'h8000_0000);
      check("A_stall", 32'(fetch_stall), 32'h0);
      tick();
      settle();
      check("B_stall", 32'(fetch_stall), 32'h0);
      check("B_req_addr", imem_req_addr, 32'h8000_0004);
      check("B_IF_valid", 32'(IF_valid), 32'(BYP));
      tick();
      imem_req_ready = 1'b0;
      settle();
      check("C_IF_valid", 32'(IF_valid), 32'h1);
      check("C_IF_instr", IF_instr, BYP ? 32'h0010_8113 : 32'h0050_0093);
      check("C_IF_PC", IF_PC, BYP ? 32'h8000_0004 : 32'h8000_0000);
      check("C_stall", 32'(fetch_stall), 32'h1);
      tick();
      settle();
      check("D_IF_valid", 32'(IF_valid), 32'(!BYP));
      tick();
      settle();
      check("E_IF_valid", 32'(IF_valid), 32'h0);

      // Backpressure: fill 4 entries, then one pop lets exactly one request out.
      ID_ready = 1'b0; imem_req_ready = 1'b1;
      ticks(6);
      settle();
      check("bp_req_valid", 32'(imem_req_valid), 32'h0);
      check("bp_stall", 32'(fetch_stall), 32'h1);
      check("bp_IF_PC", IF_PC, 32'h8000_0008);
      check("bp_IF_instr", IF_instr, 32'h0008_0013);
      snap = n_issued;
      ID_ready = 1'b1;
      tick();
      ID_ready = 1'b0;
      settle();
      check("bp_pop_req_valid", 32'(imem_req_valid), 32'h1);
      check("bp_pop_req_addr", imem_req_addr, 32'h8000_0018);
      check("bp_pop_IF_PC", IF_PC, 32'h8000_000C);
      check("bp_pop_IF_instr", IF_instr, 32'h000C_0013);
      ticks(5);
      check("bp_one_issue", 32'(n_issued - snap), 32'h1);

      // Flush with 2 outstanding and one buffered entry.
      ID_ready = 1'b1; imem_req_ready = 1'b0;
      ticks(8);
      imem_req_ready = 1'b1; ID_ready = 1'b0;
      tick();
      resp_hold = 1'b1;
      tick();
      tick();
      flush = 1'b1; redirect_pc = 32'h8000_0100;
      settle();
      check("fl_stall", 32'(fetch_stall), 32'h0);
      check("fl_req_valid", 32'(imem_req_valid), 32'h0);
      check("fl_IF_valid", 32'(IF_valid), 32'h1);
      tick();
      flush = 1'b0; resp_hold = 1'b0;
      settle();
      check("fl1_IF_valid", 32'(IF_valid), 32'h0);
      check("fl1_req_valid", 32'(imem_req_valid), 32'h0);
      tick();
      settle();
      check("fl2_IF_valid", 32'(IF_valid), 32'h0);
      tick();
      settle();
      check("fl3_IF_valid", 32'(IF_valid), 32'h0);
      check("fl3_req_valid", 32'(imem_req_valid), 32'h1);
      check("fl3_req_addr", imem_req_addr, 32'h8000_0100);
      tick();
      settle();
      check("fl4_IF_valid", 32'(IF_valid), 32'(BYP));
      tick();
      settle();
      check("fl5_IF_valid", 32'(IF_valid), 32'h1);
      check("fl5_IF_PC", IF_PC, 32'h8000_0100);
      check("fl5_IF_instr", IF_instr, 32'h0100_0013);

      // Flush coinciding with a response: it and the next one are dropped.
      ID_ready = 1'b1; imem_req_ready = 1'b0;
      ticks(10);
      imem_req_ready = 1'b1; ID_ready = 1'b0; resp_hold = 1'b1;
      tick();
      tick();
      resp_hold = 1'b0;
      tick();
      flush = 1'b1; redirect_pc = 32'h8000_0200;
      settle();
      check("fr_resp_on_bus", 32'(imem_resp_valid), 32'h1);
      check("fr_IF_valid", 32'(IF_valid), 32'h0);
      check("fr_stall", 32'(fetch_stall), 32'h0);
      tick();
      flush = 1'b0;
      settle();
      check("fr1_IF_valid", 32'(IF_valid), 32'h0);
      check("fr1_req_valid", 32'(imem_req_valid), 32'h1);
      check("fr1_req_addr", imem_req_addr, 32'h8000_0200);
      tick();
      settle();
      check("fr2_IF_valid", 32'(IF_valid), 32'(BYP));
      tick();
      settle();
      check("fr3_IF_valid", 32'(IF_valid), 32'h1);
      check("fr3_IF_PC", IF_PC, 32'h8000_0200);
      check("fr3_IF_instr", IF_instr, 32'h0200_0013);

      // Reset mid-stream with one outstanding, then a stale response.
      ID_ready = 1'b1; imem_req_ready = 1'b0;
      ticks(10);
      imem_req_ready = 1'b1; resp_hold = 1'b1;
      tick();
      imem_req_ready = 1'b0; rst = 1'b1;
      tick();
      settle();
      check("mr_IF_valid", 32'(IF_valid), 32'h0);
      check("mr_req_valid", 32'(imem_req_valid), 32'h0);
      check("mr_stall", 32'(fetch_stall), 32'h1);
      check("mr_IF_instr", IF_instr, 32'h0000_0013);
      check("mr_IF_PC", IF_PC, 32'h8000_0000);
      tick();
      rst = 1'b0; pend.delete();
      imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
      settle();
      check("stale_IF_valid", 32'(IF_valid), 32'h0);
      check("stale_req_valid", 32'(imem_req_valid), 32'h1);
      tick();
      settle();
      check("stale1_IF_valid", 32'(IF_valid), 32'h0);
      check("stale1_req_valid", 32'(imem_req_valid), 32'h1);
      check("stale1_stall", 32'(fetch_stall), 32'h1);

      // Response latency into an empty FIFO, with and without bypass.
      ID_ready = 1'b0; imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0; pend.delete();
      imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
      settle();
      check("byp_IF_valid", 32'(IF_valid), 32'(BYP));
      tick();
      settle();
      check("byp1_IF_valid", 32'(IF_valid), 32'h1);
      check("byp1_IF_instr", IF_instr, 32'h0000_0013);
      check("byp1_IF_PC", IF_PC, 32'h8000_0000);

      // Drain and finish.
      resp_hold = 1'b0; ID_ready = 1'b1;
      ticks(10);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- DEPTH, 4, instruction FIFO entries, power of two
- MAX_OUTSTANDING, 2, maximum unanswered imem requests
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- PC  in  32  current fetch address from PC register
- flush  in  1  redirect (branch, mispredict, CSR trap) this cycle
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  request address (= PC)
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  instruction returned (in request order)
- imem_resp_data  in  32  instruction word
- fetch_stall  out  1  PC SHALL hold this cycle
- IF_valid  out  1  entry available to decode
- IF_instr  out  32  instruction at FIFO head
- IF_PC  out  32  address of IF_instr
- ID_ready  in  1  decode consumes head
REQ-003 SHALL use one clock (clk) and a synchronous, active-high reset (rst).

Function
REQ-004 SHALL assert imem_req_valid when !rst, !flush, outstanding < MAX_OUTSTANDING, and fifo_count + outstanding < DEPTH.
REQ-005 SHALL drive imem_req_addr = PC combinationally.
REQ-006 Issue fires on imem_req_valid & imem_req_ready. SHALL push PC into an in-order tag queue (MAX_OUTSTANDING deep) and increment outstanding.
REQ-007 SHALL drive fetch_stall = !(issue fire). It SHALL be 0 during a flush cycle so the PC register accepts the redirect.
REQ-008 On imem_resp_valid with kill_cnt == 0: SHALL pop the tag queue, push {tag PC, imem_resp_data} into the FIFO, and decrement outstanding.
REQ-009 On imem_resp_valid with kill_cnt > 0: SHALL discard the data, pop the tag, and decrement both kill_cnt and outstanding.
REQ-010 Pop fires on IF_valid & ID_ready. Head advances with pointer wrap modulo DEPTH.
REQ-011 SHALL drive IF_valid = (fifo_count != 0), plus the bypass case of REQ-020. IF_instr and IF_PC SHALL come from the head entry.
REQ-012 Flush SHALL empty the FIFO (count 0, pointers equal) on the next edge.
REQ-013 Flush SHALL set kill_cnt to outstanding minus any response arriving in the same cycle; that response is itself discarded.
REQ-014 Flush SHALL suppress both pop and issue in its cycle.
REQ-015 Push and pop in the same cycle SHALL leave count unchanged, including at count == DEPTH-1 and with count full.
REQ-016 Issue and response in the same cycle SHALL leave outstanding unchanged. The tag queue SHALL push and pop correctly across wrap.
REQ-017 A response with outstanding == 0 is a protocol error. SHALL be ignored, with state unchanged.
REQ-018 By construction (REQ-004), the FIFO SHALL never overflow.

Reset
REQ-019 While rst is high, at each posedge: fifo_count=0, pointers=0, outstanding=0, kill_cnt=0, tag queue empty. Outputs SHALL be IF_valid=0, imem_req_valid=0, fetch_stall=1. IF_instr and IF_PC SHALL be 32'h0000_0013 (NOP) and 32'h8000_0000. Reset SHALL override flush and any in-flight response.

Configuration
REQ-020 Macro FETCH_BUF_BYPASS_EN:
- Defined: when the FIFO is empty, kill_cnt == 0, !flush and imem_resp_valid, the response SHALL appear on IF_* the same cycle with IF_valid=1. If ID_ready=1 it is consumed and not written; otherwise it is pushed.
- Undefined: every response SHALL pass through the FIFO; minimum response-to-IF_valid latency is 1 cycle.

Verification
REQ-021 Benches SHALL cover:
- Reset, then stream: PC=8000_0000, 8000_0004; ready=1, 1-cycle responses 0x00500093, 0x00108113 -> IF_* shows both in order with matching IF_PC; fetch_stall low while issuing.
- Backpressure: ID_ready=0 -> after 4 entries + 0 outstanding, imem_req_valid=0 and fetch_stall=1; one pop -> exactly one new request issues.
- Flush with 2 outstanding: flush at cycle N -> FIFO empty at N+1; next 2 responses discarded; first request after flush uses new PC 8000_0100 and its response appears.
- Flush coinciding with a response: kill_cnt=1 -> that response and the next one are dropped; the third response is kept.
- rst asserted mid-stream with 1 outstanding -> all outputs at reset values next cycle; a stale response is ignored.
- Bypass: with FETCH_BUF_BYPASS_EN, empty FIFO, response 0x00000013 -> IF_valid the same cycle; without the macro -> IF_valid one cycle later.
